// File: rtl/instruction_cycle_pkg.sv
// Shared types and constants for the multi-cycle instruction sequencer.
package instruction_cycle_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5,
    HALT      = 3'd6,
    ERROR     = 3'd7
  } state_e;

  localparam logic [3:0] DEFAULT_HALT_OPCODE = 4'hF;

  // Memory-class instructions are those with the opcode MSB set.
  function automatic logic is_mem_class(input logic op_msb, input logic mem_stage_en);
    return op_msb & mem_stage_en;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts wait cycles of a pending memory request and flags when the allowance runs out.
module mem_wait_timer #(
  parameter int unsigned MEM_WAIT_MAX = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic ack,
  output logic expire
);

  localparam int unsigned WAIT_W = (MEM_WAIT_MAX > 2) ? $clog2(MEM_WAIT_MAX) : 1;

  logic [WAIT_W-1:0] wait_cnt;

  // Expires on the last allowed cycle only if ack is still absent; zero disables it.
  assign expire = (MEM_WAIT_MAX != 0) && enable && !ack &&
                  (wait_cnt == WAIT_W'(MEM_WAIT_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (clear) begin
      wait_cnt <= '0;
    end else if ((MEM_WAIT_MAX != 0) && enable && !ack && !expire) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

endmodule

// File: rtl/instruction_cycle_ctrl.sv
// Fetch/decode/execute/memory/writeback sequencer with memory handshake timeout,
// execute stall, halt opcode and retired-instruction counter.
module instruction_cycle_ctrl
  import instruction_cycle_pkg::*;
#(
  parameter int unsigned          OPCODE_W     = 4,
  parameter logic [OPCODE_W-1:0]  HALT_OPCODE  = OPCODE_W'(DEFAULT_HALT_OPCODE),
  parameter bit                   MEM_STAGE_EN = 1'b1,
  parameter int unsigned          MEM_WAIT_MAX = 16,
  parameter int unsigned          CNT_W        = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mem_ack,
  input  logic                stall,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                fetch,
  output logic                decode,
  output logic                execute,
  output logic                memory,
  output logic                writeback,
  output logic                mem_req,
  output logic                ir_load,
  output logic                pc_inc,
  output logic                halted,
  output logic                timeout_err,
  output logic [CNT_W-1:0]    instr_count
);

  state_e state_q, state_d;
  logic   mem_op_q;
  logic   in_wait;
  logic   wait_clear;
  logic   wait_expire;

  assign in_wait    = (state_q == FETCH) || (state_q == MEMORY);
  assign wait_clear = ((state_d == FETCH) || (state_d == MEMORY)) && !in_wait;

  mem_wait_timer #(
    .MEM_WAIT_MAX (MEM_WAIT_MAX)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (reset),
    .clear  (wait_clear),
    .enable (in_wait),
    .ack    (mem_ack),
    .expire (wait_expire)
  );

  // Next-state; ir_load/pc_inc fire in the FETCH cycle that sees the ack.
  always_comb begin
    state_d = state_q;
    ir_load = 1'b0;
    pc_inc  = 1'b0;
    case (state_q)
      IDLE:      if (start) state_d = FETCH;
      FETCH: begin
        if (mem_ack) begin
          state_d = DECODE;
          ir_load = 1'b1;
          pc_inc  = 1'b1;
        end else if (wait_expire) begin
          state_d = ERROR;
        end
      end
      DECODE:    state_d = (opcode == HALT_OPCODE) ? HALT : EXECUTE;
      EXECUTE:   if (!stall) state_d = mem_op_q ? MEMORY : WRITEBACK;
      MEMORY: begin
        if (mem_ack)          state_d = WRITEBACK;
        else if (wait_expire) state_d = ERROR;
      end
      WRITEBACK: state_d = FETCH;
      HALT:      if (start) state_d = FETCH;
      ERROR:     state_d = ERROR;
      default:   state_d = IDLE;
    endcase
  end

  // State, decoded Moore outputs (registered from next state) and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_op_q    <= 1'b0;
      instr_count <= '0;
      fetch       <= 1'b0;
      decode      <= 1'b0;
      execute     <= 1'b0;
      memory      <= 1'b0;
      writeback   <= 1'b0;
      mem_req     <= 1'b0;
      halted      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) begin
        mem_op_q <= is_mem_class(opcode[OPCODE_W-1], MEM_STAGE_EN);
      end
      if (state_q == WRITEBACK) begin
        instr_count <= instr_count + CNT_W'(1);
      end
      fetch       <= (state_d == FETCH);
      decode      <= (state_d == DECODE);
      execute     <= (state_d == EXECUTE);
      memory      <= (state_d == MEMORY);
      writeback   <= (state_d == WRITEBACK);
      mem_req     <= (state_d == FETCH) || (state_d == MEMORY);
      halted      <= (state_d == HALT);
      timeout_err <= (state_d == ERROR);
    end
  end

endmodule

// File: tb/tb_instruction_cycle_ctrl.sv
// Self-checking bench for instruction_cycle_ctrl: per-cycle vector tables with a scoreboard queue.
module tb_instruction_cycle_ctrl;

  localparam logic [2:0] SI = 3'd0, SF = 3'd1, SD = 3'd2, SE = 3'd3,
                         SM = 3'd4, SW = 3'd5, SH = 3'd6, SX = 3'd7;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       start_nm = 1'b0;
  logic       mem_ack = 1'b0;
  logic       stall = 1'b0;
  logic [3:0] opcode = 4'h0;

  logic        fetch, decode, execute, memory, writeback, mem_req, ir_load, pc_inc, halted, timeout_err;
  logic [15:0] instr_count;
  logic        n_fetch, n_decode, n_execute, n_memory, n_writeback, n_mem_req, n_ir_load, n_pc_inc;
  logic        n_halted, n_timeout_err;
  logic [15:0] n_instr_count;

  always #5 clk = ~clk;

  instruction_cycle_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .mem_ack(mem_ack), .stall(stall), .opcode(opcode),
    .fetch(fetch), .decode(decode), .execute(execute), .memory(memory), .writeback(writeback),
    .mem_req(mem_req), .ir_load(ir_load), .pc_inc(pc_inc), .halted(halted),
    .timeout_err(timeout_err), .instr_count(instr_count)
  );

  instruction_cycle_ctrl #(.MEM_STAGE_EN(1'b0)) dut_nm (
    .clk(clk), .reset(reset), .start(start_nm), .mem_ack(mem_ack), .stall(stall), .opcode(opcode),
    .fetch(n_fetch), .decode(n_decode), .execute(n_execute), .memory(n_memory),
    .writeback(n_writeback), .mem_req(n_mem_req), .ir_load(n_ir_load), .pc_inc(n_pc_inc),
    .halted(n_halted), .timeout_err(n_timeout_err), .instr_count(n_instr_count)
  );

  typedef struct {
    logic        sel;
    logic        st;
    logic        ack;
    logic        stl;
    logic [3:0]  op;
    logic [2:0]  stg;
    logic        ld;
    int unsigned cnt;
  } vec_t;

  typedef struct {
    logic        sel;
    logic [9:0]  bits;
    logic [15:0] cnt;
    int unsigned idx;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Output order: fetch decode execute memory writeback mem_req ir_load pc_inc halted timeout_err
  function automatic logic [9:0] stage_bits(input logic [2:0] stg, input logic ld);
    return {stg == SF, stg == SD, stg == SE, stg == SM, stg == SW,
            (stg == SF) || (stg == SM), ld, ld, stg == SH, stg == SX};
  endfunction

  function automatic exp_t mk_exp(input logic sel, input logic [2:0] stg, input logic ld,
                                  input int unsigned cnt, input int unsigned idx);
    exp_t e;
    e.sel  = sel;
    e.bits = stage_bits(stg, ld);
    e.cnt  = 16'(cnt);
    e.idx  = idx;
    return e;
  endfunction

  task automatic add(input logic sel, input logic st, input logic ack, input logic stl,
                     input logic [3:0] op, input logic [2:0] stg, input logic ld,
                     input int unsigned cnt);
    vec_t v;
    v.sel = sel; v.st = st; v.ack = ack; v.stl = stl;
    v.op = op; v.stg = stg; v.ld = ld; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic compare(input string name, input exp_t e);
    logic [9:0]  act;
    logic [15:0] acnt;
    if (e.sel) begin
      act  = {n_fetch, n_decode, n_execute, n_memory, n_writeback, n_mem_req, n_ir_load,
              n_pc_inc, n_halted, n_timeout_err};
      acnt = n_instr_count;
    end else begin
      act  = {fetch, decode, execute, memory, writeback, mem_req, ir_load, pc_inc,
              halted, timeout_err};
      acnt = instr_count;
    end
    n_cmp++;
    if (act !== e.bits || acnt !== e.cnt) begin
      n_bad++;
      $display("FAIL %s[%0d]: got outputs=%b count=%0d, expected outputs=%b count=%0d",
               name, e.idx, act, acnt, e.bits, e.cnt);
    end
  endtask

  // Drive one vector per cycle at the falling edge, check just after.
  task automatic run_vecs(input string name);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      start    = vecs[i].sel ? 1'b0 : vecs[i].st;
      start_nm = vecs[i].sel ? vecs[i].st : 1'b0;
      mem_ack  = vecs[i].ack;
      stall    = vecs[i].stl;
      opcode   = vecs[i].op;
      exp_q.push_back(mk_exp(vecs[i].sel, vecs[i].stg, vecs[i].ld, vecs[i].cnt, i));
      #1;
      compare(name, exp_q.pop_front());
    end
    vecs.delete();
  endtask

  initial begin
    // Reset held for two cycles
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      exp_q.push_back(mk_exp(1'b0, SI, 1'b0, 0, i));
      exp_q.push_back(mk_exp(1'b1, SI, 1'b0, 0, i));
      #1;
      compare("reset", exp_q.pop_front());
      compare("reset_nm", exp_q.pop_front());
    end
    reset = 1'b1;

    // Plain ALU instructions, ack tied high; stray stall/start ignored
    add(0, 1, 1, 0, 4'h1, SI, 0, 0);
    for (int i = 0; i < 3; i++) begin
      add(0, 0, 1, (i == 1), 4'h1, SF, 1, i);
      add(0, 0, 1, 0, 4'h1, SD, 0, i);
      add(0, 1, 1, 0, 4'h1, SE, 0, i);
      add(0, 0, 1, 0, 4'h1, SW, 0, i);
    end
    // Memory-class instructions visit MEMORY
    for (int i = 3; i < 5; i++) begin
      add(0, 0, 1, 0, 4'h9, SF, 1, i);
      add(0, 0, 1, 0, 4'h9, SD, 0, i);
      add(0, 0, 1, 0, 4'h9, SE, 0, i);
      add(0, 0, 1, 0, 4'h9, SM, 0, i);
      add(0, 0, 1, 0, 4'h9, SW, 0, i);
    end
    // Three fetch wait cycles, then five stall cycles
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 4'h1, SF, 0, 5);
    add(0, 0, 1, 0, 4'h1, SF, 1, 5);
    add(0, 0, 1, 0, 4'h1, SD, 0, 5);
    for (int i = 0; i < 5; i++) add(0, 0, 1, 1, 4'h1, SE, 0, 5);
    add(0, 0, 1, 0, 4'h1, SE, 0, 5);
    add(0, 0, 1, 0, 4'h1, SW, 0, 5);
    // Halt opcode: not counted, restart with start
    add(0, 0, 1, 0, 4'h1, SF, 1, 6);
    add(0, 0, 1, 0, 4'hF, SD, 0, 6);
    add(0, 0, 1, 1, 4'h1, SH, 0, 6);
    add(0, 0, 0, 0, 4'h1, SH, 0, 6);
    add(0, 1, 0, 0, 4'h1, SH, 0, 6);
    add(0, 0, 1, 0, 4'h1, SF, 1, 6);
    add(0, 0, 1, 0, 4'h1, SD, 0, 6);
    add(0, 0, 1, 0, 4'h1, SE, 0, 6);
    add(0, 0, 1, 0, 4'h1, SW, 0, 6);
    // Ack on the 16th wait cycle still succeeds
    for (int i = 0; i < 15; i++) add(0, 0, 0, 0, 4'h1, SF, 0, 7);
    add(0, 0, 1, 0, 4'h1, SF, 1, 7);
    add(0, 0, 1, 0, 4'h1, SD, 0, 7);
    add(0, 0, 1, 0, 4'h1, SE, 0, 7);
    add(0, 0, 1, 0, 4'h1, SW, 0, 7);
    // Sixteen cycles without ack: ERROR, sticky through start pulses
    for (int i = 0; i < 16; i++) add(0, 0, 0, 0, 4'h1, SF, 0, 8);
    add(0, 1, 0, 0, 4'h1, SX, 0, 8);
    add(0, 0, 0, 0, 4'h1, SX, 0, 8);
    add(0, 1, 1, 0, 4'h1, SX, 0, 8);
    add(0, 0, 1, 0, 4'h1, SX, 0, 8);
    run_vecs("main");

    // Reset clears ERROR
    @(negedge clk);
    #2 reset = 1'b0;
    exp_q.push_back(mk_exp(1'b0, SI, 1'b0, 0, 0));
    #1 compare("err_reset", exp_q.pop_front());
    @(negedge clk);
    #1 reset = 1'b1;

    // Run into MEMORY with a counted instruction behind us
    add(0, 1, 1, 0, 4'h9, SI, 0, 0);
    add(0, 0, 1, 0, 4'h9, SF, 1, 0);
    add(0, 0, 1, 0, 4'h9, SD, 0, 0);
    add(0, 0, 1, 0, 4'h9, SE, 0, 0);
    add(0, 0, 1, 0, 4'h9, SM, 0, 0);
    add(0, 0, 1, 0, 4'h9, SW, 0, 0);
    add(0, 0, 1, 0, 4'h9, SF, 1, 1);
    add(0, 0, 1, 0, 4'h9, SD, 0, 1);
    add(0, 0, 1, 0, 4'h9, SE, 0, 1);
    add(0, 0, 0, 0, 4'h9, SM, 0, 1);
    add(0, 0, 0, 0, 4'h9, SM, 0, 1);
    run_vecs("pre_reset");

    // Asynchronous reset between clock edges while in MEMORY
    #2 reset = 1'b0;
    exp_q.push_back(mk_exp(1'b0, SI, 1'b0, 0, 0));
    #1 compare("async_reset", exp_q.pop_front());
    @(negedge clk);
    #1 reset = 1'b1;

    // After release: stays IDLE until start
    for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 4'h1, SI, 0, 0);
    add(0, 1, 1, 0, 4'h1, SI, 0, 0);
    add(0, 0, 1, 0, 4'h1, SF, 1, 0);
    run_vecs("post_reset");

    // MEMORY stage disabled: memory-class opcodes take the 4-cycle path
    add(1, 1, 1, 0, 4'h9, SI, 0, 0);
    for (int i = 0; i < 2; i++) begin
      add(1, 0, 1, 0, 4'h9, SF, 1, i);
      add(1, 0, 1, 0, 4'h9, SD, 0, i);
      add(1, 0, 1, 0, 4'h9, SE, 0, i);
      add(1, 0, 1, 0, 4'h9, SW, 0, i);
    end
    add(1, 0, 1, 0, 4'h9, SF, 1, 2);
    run_vecs("no_mem_stage");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
